// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu round-robin scheduler.
//   OP_*    : fpu opcode encoding passed through unmodified
//   state_e : scheduler FSM state encoding
//   F32_W   : IEEE-754 single-precision word width
package fpu_pkg;

   localparam int unsigned F32_W = 32;
   localparam int unsigned OP_W  = 2;

   localparam logic [OP_W-1:0] OP_ADD = 2'b00;
   localparam logic [OP_W-1:0] OP_SUB = 2'b01;
   localparam logic [OP_W-1:0] OP_DIV = 2'b10;
   localparam logic [OP_W-1:0] OP_MUL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_e;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : highest-priority index; search ascends from here, wrapping
//   en  : when low, no grant is produced
//   gnt : one-hot grant
//   idx : encoded index of the granted requester
//   any : a grant was issued
module fpu_rr_arbiter #(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   // First requester found at or after ptr wins.
   always_comb begin
      logic [IDW-1:0] j;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = '0;
      if (en) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            j = IDW'((32'(ptr) + i) % NREQ);
            if (!any && req[j]) begin
               any    = 1'b1;
               gnt[j] = 1'b1;
               idx    = j;
            end
         end
      end
   end

endmodule

// File: rtl/fpu_rr_scheduler.sv
// Shares one fpu datapath among NREQ requesters with round-robin arbitration.
// One operation in flight; operands held on fpu_a/b/opcode until the next accept.
//   clk, rst           : clock, asynchronous active-high reset
//   req_valid/ready    : per-requester handshake (req_ready is a one-hot grant)
//   req_a/b/op         : packed per-requester operands and opcode
//   rsp_valid/ready    : result handshake, rsp_id tags the issuing requester
//   rsp_data           : fpu result
//   fpu_a/b/opcode/o   : connection to the shared fpu
//   busy               : FSM not idle
module fpu_rr_scheduler
   import fpu_pkg::*;
#(
   parameter  int unsigned NREQ     = 4,
   parameter  int unsigned FAST_LAT = 2,
   parameter  int unsigned DIV_LAT  = 4,
   localparam int unsigned IDW      = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*F32_W-1:0] req_a,
   input  logic [NREQ*F32_W-1:0] req_b,
   input  logic [NREQ*OP_W-1:0]  req_op,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [F32_W-1:0]      rsp_data,
   output logic [F32_W-1:0]      fpu_a,
   output logic [F32_W-1:0]      fpu_b,
   output logic [OP_W-1:0]       fpu_opcode,
   input  logic [F32_W-1:0]      fpu_o,
   output logic                  busy
);

   localparam int unsigned MAX_LAT = (DIV_LAT > FAST_LAT) ? DIV_LAT : FAST_LAT;
   localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [F32_W-1:0]  fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
   logic [OP_W-1:0]   fpu_op_q, fpu_op_d;
   logic [IDW-1:0]    rsp_id_q, rsp_id_d;
   logic [F32_W-1:0]  rsp_data_q, rsp_data_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              busy_q, busy_d;

   logic              arb_en_c;
   logic [NREQ-1:0]   arb_gnt;
   logic [IDW-1:0]    arb_idx;
   logic              arb_any;
   logic [OP_W-1:0]   win_op;

   // Grants only when a new operation can start; masked in reset so all outputs read 0.
   assign arb_en_c = ~rst & ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));

   fpu_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req (req_valid),
      .ptr (ptr_q),
      .en  (arb_en_c),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign win_op = req_op[OP_W*arb_idx +: OP_W];

   // Next-state and register-input logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      fpu_a_d     = fpu_a_q;
      fpu_b_d     = fpu_b_q;
      fpu_op_d    = fpu_op_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = rsp_valid_q;

      case (state_q)
         ST_WAIT: begin
            if (cnt_q == '0) begin
               rsp_data_d  = fpu_o;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // arb_any is only possible in IDLE or in RESP with rsp_ready.
      if (arb_any) begin
         fpu_a_d  = req_a[F32_W*arb_idx +: F32_W];
         fpu_b_d  = req_b[F32_W*arb_idx +: F32_W];
         fpu_op_d = win_op;
         rsp_id_d = arb_idx;
         cnt_d    = (win_op == OP_DIV) ? CNT_W'(DIV_LAT - 2) : CNT_W'(FAST_LAT - 2);
         ptr_d    = (arb_idx == IDW'(NREQ - 1)) ? '0 : IDW'(arb_idx + IDW'(1));
         state_d  = ST_WAIT;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         ptr_q       <= '0;
         fpu_a_q     <= '0;
         fpu_b_q     <= '0;
         fpu_op_q    <= '0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         fpu_a_q     <= fpu_a_d;
         fpu_b_q     <= fpu_b_d;
         fpu_op_q    <= fpu_op_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign req_ready  = arb_gnt;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_data   = rsp_data_q;
   assign fpu_a      = fpu_a_q;
   assign fpu_b      = fpu_b_q;
   assign fpu_opcode = fpu_op_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Scoreboard bench for fpu_rr_scheduler: stimulus pushes expected responses,
// a negedge monitor pops and compares on each response handshake.
module tb_fpu_rr_scheduler;
   import fpu_pkg::*;

   localparam int unsigned NREQ = 4;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*32-1:0]    req_a = '0;
   logic [NREQ*32-1:0]    req_b = '0;
   logic [NREQ*2-1:0]     req_op = '0;
   logic                  rsp_valid;
   logic                  rsp_ready = 1'b1;
   logic [1:0]            rsp_id;
   logic [31:0]           rsp_data;
   logic [31:0]           fpu_a, fpu_b, fpu_o;
   logic [1:0]            fpu_opcode;
   logic                  busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
      int          acc;
      int          lat;
   } exp_t;
   exp_t sb[$];

   fpu_rr_scheduler #(.NREQ(NREQ), .FAST_LAT(2), .DIV_LAT(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode),
      .fpu_o(fpu_o), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Combinational fpu stand-in: lookup of hand-computed single-precision results.
   function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
      logic [65:0] key;
      key = {op, a, b};
      case (key)
         {OP_ADD, 32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2
         {OP_MUL, 32'h40400000, 32'h40000000}: return 32'h40C00000; // 3*2
         {OP_DIV, 32'h40C00000, 32'h40000000}: return 32'h40400000; // 6/2
         {OP_ADD, 32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1
         {OP_SUB, 32'h40A00000, 32'h3F800000}: return 32'h40800000; // 5-1
         {OP_MUL, 32'h40000000, 32'h40800000}: return 32'h41000000; // 2*4
         {OP_DIV, 32'h41000000, 32'h40000000}: return 32'h40800000; // 8/2
         default:                              return 32'hDEADBEEF;
      endcase
   endfunction

   assign fpu_o = fpu_model(fpu_a, fpu_b, fpu_opcode);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op);
      req_a[32*r +: 32] = a;
      req_b[32*r +: 32] = b;
      req_op[2*r +: 2]  = op;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for a grant at a negedge, checks it and pushes the expected response.
   task automatic expect_grant(input logic [3:0] exp_gnt, input logic [1:0] id,
                               input logic [31:0] data, input int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (req_ready == '0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (req_ready !== exp_gnt) begin
         failures++;
         $display("FAIL grant: got %b expected %b (cycle %0d)", req_ready, exp_gnt, cyc);
      end else begin
         sb.push_back('{id: id, data: data, acc: cyc, lat: lat});
      end
   endtask

   // Response monitor.
   int  rise_cyc = 0;
   logic v_prev  = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         v_prev = 1'b0;
      end else begin
         if (rsp_valid && !v_prev) rise_cyc = cyc;
         if (rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_rsp: id %0d data %h with empty scoreboard", rsp_id, rsp_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (rsp_id !== e.id || rsp_data !== e.data || (rise_cyc - e.acc) != e.lat) begin
                  failures++;
                  $display("FAIL rsp: got id %0d data %h lat %0d expected id %0d data %h lat %0d",
                           rsp_id, rsp_data, rise_cyc - e.acc, e.id, e.data, e.lat);
               end
            end
         end
         v_prev = rsp_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset state
      #12;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fpu_a", fpu_a, 32'd0);
      step();
      rst = 1'b0;
      step();

      // ADD on requester 0
      set_req(0, 32'h3F800000, 32'h40000000, OP_ADD);
      req_valid = 4'b0001;
      expect_grant(4'b0001, 2'd0, 32'h40400000, 2);
      step();
      req_valid = '0;
      repeat (3) step();

      // MUL on requester 3
      set_req(3, 32'h40400000, 32'h40000000, OP_MUL);
      req_valid = 4'b1000;
      expect_grant(4'b1000, 2'd3, 32'h40C00000, 2);
      step();
      req_valid = '0;
      repeat (3) step();

      // DIV on requester 1: operands stable T+1..T+4
      set_req(1, 32'h40C00000, 32'h40000000, OP_DIV);
      req_valid = 4'b0010;
      expect_grant(4'b0010, 2'd1, 32'h40400000, 4);
      step();
      req_valid = '0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("div_fpu_a_stable", fpu_a, 32'h40C00000);
         chk("div_fpu_b_stable", fpu_b, 32'h40000000);
         chk("div_opcode_stable", 32'(fpu_opcode), 32'(OP_DIV));
         step();
      end
      repeat (2) step();

      // Reset during a DIV: asserted at T+1, outputs cleared without a clock edge
      req_valid = 4'b0010;
      expect_grant(4'b0010, 2'd1, 32'h40400000, 4);
      step();
      req_valid = 4'b1111;
      rst = 1'b1;
      #1;
      sb.delete();
      chk("arst_req_ready", 32'(req_ready), 32'd0);
      chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("arst_rsp_id", 32'(rsp_id), 32'd0);
      chk("arst_rsp_data", rsp_data, 32'd0);
      chk("arst_fpu_a", fpu_a, 32'd0);
      chk("arst_fpu_b", fpu_b, 32'd0);
      chk("arst_fpu_opcode", 32'(fpu_opcode), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      step();
      rst = 1'b0;
      req_valid = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
         step();
      end

      // Fairness: all valid, rsp_ready=1 -> 0,1,2,3,0,1
      set_req(0, 32'h3F800000, 32'h3F800000, OP_ADD);
      set_req(1, 32'h40A00000, 32'h3F800000, OP_SUB);
      set_req(2, 32'h40000000, 32'h40800000, OP_MUL);
      set_req(3, 32'h41000000, 32'h40000000, OP_DIV);
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         logic [1:0]  g;
         logic [31:0] d;
         g = 2'(k % 4);
         case (g)
            2'd0: d = 32'h40000000;
            2'd1: d = 32'h40800000;
            2'd2: d = 32'h41000000;
            default: d = 32'h40800000;
         endcase
         expect_grant(4'b0001 << g, g, d, (g == 2'd3) ? 4 : 2);
         step();
      end
      req_valid = '0;
      repeat (4) step();

      // Backpressure with requester 2 waiting
      rsp_ready = 1'b0;
      set_req(0, 32'h3F800000, 32'h40000000, OP_ADD);
      req_valid = 4'b0001;
      expect_grant(4'b0001, 2'd0, 32'h40400000, 2);
      step();
      set_req(2, 32'h40400000, 32'h40000000, OP_MUL);
      req_valid = 4'b0100;
      @(negedge clk);
      chk("wait_req_ready", 32'(req_ready), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp_id", 32'(rsp_id), 32'd0);
         chk("bp_rsp_data", rsp_data, 32'h40400000);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_grant", 32'(req_ready), 32'b0100);
      expect_grant(4'b0100, 2'd2, 32'h40C00000, 2);
      step();
      req_valid = '0;
      @(negedge clk);
      chk("rsp_valid_drops", 32'(rsp_valid), 32'd0);

      // Drain
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         step();
         n++;
      end
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
